// File: rtl/sfr_pkg.sv
// Shared types, window constants and helpers for the SFR bus bridge.
// Used by sfr_bus_bridge, sfr_addr_decode and the SFR map.
package sfr_pkg;

    localparam int unsigned SFR_W     = 32;
    localparam logic [31:0] SFR_BASE  = 32'h0000_F000;
    localparam int unsigned SFR_COUNT = 16;
    localparam int unsigned SFR_IDX_W = $clog2(SFR_COUNT);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        WRITE,
        RESP
    } state_e;

    // Widen each byte-enable bit to cover its 8 data bits.
    function automatic logic [SFR_W-1:0] be_to_mask(
        input logic [SFR_W/8-1:0] be
    );
        logic [SFR_W-1:0] m;
        m = '0;
        for (int i = 0; i < SFR_W / 8; i++) begin
            m[8*i +: 8] = {8{be[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/sfr_addr_decode.sv
// Combinational SFR window decode: hit flag and register index.
// A hit needs an in-window, word-aligned byte address.
module sfr_addr_decode
    import sfr_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter logic [31:0] SFR_BASE   = sfr_pkg::SFR_BASE,
    parameter int unsigned SFR_COUNT  = sfr_pkg::SFR_COUNT
) (
    input  logic [ADDR_WIDTH-1:0]        addr_i,
    output logic                         hit_o,
    output logic [$clog2(SFR_COUNT)-1:0] idx_o
);

    localparam int unsigned IDX_W = $clog2(SFR_COUNT);
    localparam int unsigned EXT_W = ADDR_WIDTH + 1;

    // One extra bit keeps the upper bound from wrapping near the top of memory.
    localparam logic [EXT_W-1:0] LO = EXT_W'(SFR_BASE);
    localparam logic [EXT_W-1:0] HI = LO + EXT_W'(4 * SFR_COUNT);

    logic [EXT_W-1:0]      a_ext;
    logic [ADDR_WIDTH-1:0] off;

    // Range and alignment check, word offset into the window.
    always_comb begin
        a_ext = {1'b0, addr_i};
        off   = addr_i - ADDR_WIDTH'(SFR_BASE);
        hit_o = (a_ext >= LO) && (a_ext < HI) && (addr_i[1:0] == 2'b00);
        idx_o = IDX_W'(off >> 2);
    end

endmodule

// File: rtl/sfr_bus_bridge.sv
// Core data-port to SFR map bridge: decode, byte-masked RMW, one ack per request.
// Define SFR_BUS_ERR_EN to flag window misses on cpu_err.
module sfr_bus_bridge
    import sfr_pkg::*;
#(
    parameter int unsigned SFR_WIDTH  = sfr_pkg::SFR_W,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter logic [31:0] SFR_BASE   = sfr_pkg::SFR_BASE,
    parameter int unsigned SFR_COUNT  = sfr_pkg::SFR_COUNT
) (
    input  logic                         sys_clk,
    input  logic                         sys_rst,
    input  logic                         sys_clk_en,
    input  logic                         cpu_req,
    input  logic                         cpu_we,
    input  logic [ADDR_WIDTH-1:0]        cpu_addr,
    input  logic [SFR_WIDTH/8-1:0]       cpu_be,
    input  logic [SFR_WIDTH-1:0]         cpu_wdata,
    output logic                         cpu_ack,
    output logic [SFR_WIDTH-1:0]         cpu_rdata,
    output logic                         cpu_err,
    output logic [$clog2(SFR_COUNT)-1:0] sfr_sel,
    output logic                         sfr_wen,
    output logic [SFR_WIDTH-1:0]         sfr_din,
    input  logic [SFR_WIDTH-1:0]         sfr_dout,
    input  logic [SFR_WIDTH-1:0]         sfr_rdonly_dout
);

    localparam int unsigned IDX_W = $clog2(SFR_COUNT);
    localparam int unsigned BE_W  = SFR_WIDTH / 8;

    state_e               state_q, state_d;
    logic                 we_q, we_d;
    logic [BE_W-1:0]      be_q, be_d;
    logic [SFR_WIDTH-1:0] wdata_q, wdata_d;
    logic [IDX_W-1:0]     sel_q, sel_d;
    logic                 wen_q, wen_d;
    logic [SFR_WIDTH-1:0] din_q, din_d;
    logic                 ack_q, ack_d;
    logic [SFR_WIDTH-1:0] rdata_q, rdata_d;
    logic [SFR_WIDTH-1:0] wmask;
    logic                 hit;
    logic [IDX_W-1:0]     idx;
`ifdef SFR_BUS_ERR_EN
    logic                 err_q, err_d;
`endif

    sfr_addr_decode #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .SFR_BASE   (SFR_BASE),
        .SFR_COUNT  (SFR_COUNT)
    ) u_decode (
        .addr_i (cpu_addr),
        .hit_o  (hit),
        .idx_o  (idx)
    );

    // Next-state and registered-output logic; ack/wen are one-shot by default.
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        sel_d   = sel_q;
        din_d   = din_q;
        wen_d   = 1'b0;
        ack_d   = 1'b0;
        rdata_d = '0;
`ifdef SFR_BUS_ERR_EN
        err_d   = 1'b0;
`endif
        wmask   = be_to_mask(be_q) & ~sfr_rdonly_dout;
        unique case (state_q)
            IDLE: begin
                if (cpu_req) begin
                    we_d    = cpu_we;
                    be_d    = cpu_be;
                    wdata_d = cpu_wdata;
                    if (hit) begin
                        sel_d   = idx;
                        state_d = FETCH;
                    end else begin
                        ack_d   = 1'b1;
                        state_d = RESP;
`ifdef SFR_BUS_ERR_EN
                        err_d   = 1'b1;
`endif
                    end
                end
            end
            FETCH: begin
                if (we_q) begin
                    din_d   = (sfr_dout & ~wmask) | (wdata_q & wmask);
                    wen_d   = |wmask;
                    state_d = WRITE;
                end else begin
                    rdata_d = sfr_dout;
                    ack_d   = 1'b1;
                    state_d = RESP;
                end
            end
            WRITE: begin
                ack_d   = 1'b1;
                state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; a low clock enable freezes everything.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
            sel_q   <= '0;
            wen_q   <= 1'b0;
            din_q   <= '0;
            ack_q   <= 1'b0;
            rdata_q <= '0;
`ifdef SFR_BUS_ERR_EN
            err_q   <= 1'b0;
`endif
        end else if (sys_clk_en) begin
            state_q <= state_d;
            we_q    <= we_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            sel_q   <= sel_d;
            wen_q   <= wen_d;
            din_q   <= din_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
`ifdef SFR_BUS_ERR_EN
            err_q   <= err_d;
`endif
        end
    end

    // Gating keeps a frozen strobe or ack from being seen on stalled cycles.
    assign cpu_ack   = ack_q & sys_clk_en;
    assign sfr_wen   = wen_q & sys_clk_en;
    assign cpu_rdata = rdata_q;
    assign sfr_sel   = sel_q;
    assign sfr_din   = din_q;
`ifdef SFR_BUS_ERR_EN
    assign cpu_err   = err_q;
`else
    assign cpu_err   = 1'b0;
`endif

endmodule

// File: tb/tb_sfr_bus_bridge.sv
// Directed bench for sfr_bus_bridge with a small behavioural SFR map.
// Cycle numbers are counted at rising edges; outputs sampled on falling edges.
module tb_sfr_bus_bridge;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        sys_clk_en = 1'b1;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [31:0] cpu_addr = '0;
    logic [3:0]  cpu_be = '0;
    logic [31:0] cpu_wdata = '0;
    logic        cpu_ack;
    logic [31:0] cpu_rdata;
    logic        cpu_err;
    logic [3:0]  sfr_sel;
    logic        sfr_wen;
    logic [31:0] sfr_din;
    logic [31:0] sfr_dout;
    logic [31:0] sfr_rdonly_dout;

    logic [31:0] regs [16];
    logic [31:0] ro   [16];

    int passed = 0;
    int total  = 0;

    int          cyc = 0;
    int          ack_cnt = 0;
    int          wen_cnt = 0;
    int          ack_at = 0;
    int          wen_at = 0;
    logic [31:0] ack_rdata = '0;
    logic        ack_err = 1'b0;
    logic [31:0] wen_din = '0;

`ifdef SFR_BUS_ERR_EN
    localparam logic MISS_ERR = 1'b1;
`else
    localparam logic MISS_ERR = 1'b0;
`endif

    always #5 sys_clk = ~sys_clk;

    assign sfr_dout        = regs[sfr_sel];
    assign sfr_rdonly_dout = ro[sfr_sel];

    sfr_bus_bridge dut (
        .sys_clk         (sys_clk),
        .sys_rst         (sys_rst),
        .sys_clk_en      (sys_clk_en),
        .cpu_req         (cpu_req),
        .cpu_we          (cpu_we),
        .cpu_addr        (cpu_addr),
        .cpu_be          (cpu_be),
        .cpu_wdata       (cpu_wdata),
        .cpu_ack         (cpu_ack),
        .cpu_rdata       (cpu_rdata),
        .cpu_err         (cpu_err),
        .sfr_sel         (sfr_sel),
        .sfr_wen         (sfr_wen),
        .sfr_din         (sfr_din),
        .sfr_dout        (sfr_dout),
        .sfr_rdonly_dout (sfr_rdonly_dout)
    );

    // Record every ack and write strobe the core/map would see at an edge.
    always @(posedge sys_clk) begin
        cyc = cyc + 1;
        if (cpu_ack) begin
            ack_cnt   = ack_cnt + 1;
            ack_at    = cyc;
            ack_rdata = cpu_rdata;
            ack_err   = cpu_err;
        end
        if (sfr_wen) begin
            wen_cnt = wen_cnt + 1;
            wen_at  = cyc;
            wen_din = sfr_din;
        end
    end

    // Drive one request (called on a falling edge) and hold it until acked.
    task automatic access(input logic we, input logic [31:0] addr,
                          input logic [3:0] be, input logic [31:0] wd,
                          output int n, output bit ok);
        int c0;
        c0        = ack_cnt;
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_be    = be;
        cpu_wdata = wd;
        n         = cyc + 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge sys_clk);
            if (ack_cnt != c0) break;
        end
        ok = (ack_cnt != c0);
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        repeat (3) @(negedge sys_clk);
        total++;
        if ({cpu_ack, cpu_err, sfr_wen} !== 3'b000)
            $display("FAIL reset_flags: got %b expected 000",
                     {cpu_ack, cpu_err, sfr_wen});
        else passed++;
        total++;
        if (cpu_rdata !== 32'h0 || sfr_din !== 32'h0 || sfr_sel !== 4'h0)
            $display("FAIL reset_data: got rdata=%h din=%h sel=%h expected 0",
                     cpu_rdata, sfr_din, sfr_sel);
        else passed++;
        sys_rst = 1'b0;
        repeat (2) @(negedge sys_clk);
        total++;
        if (ack_cnt != 0 || wen_cnt != 0)
            $display("FAIL idle_quiet: got ack=%0d wen=%0d expected 0",
                     ack_cnt, wen_cnt);
        else passed++;
    endtask

    task automatic test_load_hit();
        int n;
        bit ok;
        int w0;
        w0 = wen_cnt;
        @(negedge sys_clk);
        access(1'b0, 32'h0000_F004, 4'h0, 32'h0, n, ok);
        cpu_req = 1'b0;
        total++;
        if (!ok || ack_at - n != 2)
            $display("FAIL load_latency: got ok=%0d lat=%0d expected 2",
                     ok, ack_at - n);
        else passed++;
        total++;
        if (ack_rdata !== 32'h1234_5678 || ack_err !== 1'b0)
            $display("FAIL load_data: got %h err=%b expected 12345678 err=0",
                     ack_rdata, ack_err);
        else passed++;
        total++;
        if (sfr_sel !== 4'd1 || wen_cnt != w0)
            $display("FAIL load_sel_hold: got sel=%0d wen=%0d expected 1 %0d",
                     sfr_sel, wen_cnt, w0);
        else passed++;
        @(negedge sys_clk);
        access(1'b0, 32'h0000_F03C, 4'h0, 32'h0, n, ok);
        cpu_req = 1'b0;
        total++;
        if (!ok || ack_at - n != 2 || ack_rdata !== 32'hCAFE_F00D)
            $display("FAIL load_top: got lat=%0d data=%h expected 2 cafef00d",
                     ack_at - n, ack_rdata);
        else passed++;
    endtask

    task automatic test_store_merge();
        int n;
        bit ok;
        int w0;
        w0 = wen_cnt;
        @(negedge sys_clk);
        access(1'b1, 32'h0000_F008, 4'b0011, 32'hAAAA_BBBB, n, ok);
        cpu_req = 1'b0;
        total++;
        if (wen_cnt != w0 + 1 || wen_at - n != 2)
            $display("FAIL store_wen: got cnt=%0d lat=%0d expected %0d 2",
                     wen_cnt - w0, wen_at - n, 1);
        else passed++;
        total++;
        if (wen_din !== 32'h1111_BB22)
            $display("FAIL store_din: got %h expected 1111bb22", wen_din);
        else passed++;
        total++;
        if (!ok || ack_at - n != 3 || ack_rdata !== 32'h0)
            $display("FAIL store_ack: got lat=%0d rdata=%h expected 3 0",
                     ack_at - n, ack_rdata);
        else passed++;
    endtask

    task automatic test_store_suppressed();
        int n;
        bit ok;
        int w0;
        w0 = wen_cnt;
        @(negedge sys_clk);
        access(1'b1, 32'h0000_F004, 4'b0000, 32'hFFFF_FFFF, n, ok);
        cpu_req = 1'b0;
        total++;
        if (wen_cnt != w0 || !ok || ack_at - n != 3)
            $display("FAIL store_be0: got wen=%0d lat=%0d expected 0 3",
                     wen_cnt - w0, ack_at - n);
        else passed++;
        @(negedge sys_clk);
        access(1'b1, 32'h0000_F00C, 4'b1111, 32'h5555_5555, n, ok);
        cpu_req = 1'b0;
        total++;
        if (wen_cnt != w0 || !ok || ack_at - n != 3)
            $display("FAIL store_ro: got wen=%0d lat=%0d expected 0 3",
                     wen_cnt - w0, ack_at - n);
        else passed++;
    endtask

    task automatic test_miss();
        int n;
        bit ok;
        int w0;
        logic [31:0] addrs [4];
        addrs[0] = 32'h0000_F040;
        addrs[1] = 32'h0000_F002;
        addrs[2] = 32'h0000_EFFC;
        addrs[3] = 32'h0000_F041;
        w0 = wen_cnt;
        for (int k = 0; k < 4; k++) begin
            @(negedge sys_clk);
            access(k == 3, addrs[k], 4'hF, 32'hDEAD_BEEF, n, ok);
            cpu_req = 1'b0;
            total++;
            if (!ok || ack_at - n != 1 || ack_rdata !== 32'h0 ||
                ack_err !== MISS_ERR)
                $display("FAIL miss_%h: got lat=%0d rdata=%h err=%b expected 1 0 %b",
                         addrs[k], ack_at - n, ack_rdata, ack_err, MISS_ERR);
            else passed++;
        end
        total++;
        if (wen_cnt != w0)
            $display("FAIL miss_no_wen: got %0d expected 0", wen_cnt - w0);
        else passed++;
    endtask

    task automatic test_clk_en();
        int n;
        int a0;
        int w0;
        bit ok;
        a0 = ack_cnt;
        w0 = wen_cnt;
        @(negedge sys_clk);
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = 32'h0000_F008;
        cpu_be    = 4'b0011;
        cpu_wdata = 32'hAAAA_BBBB;
        n = cyc + 1;
        repeat (2) @(negedge sys_clk);
        sys_clk_en = 1'b0;
        repeat (3) @(negedge sys_clk);
        sys_clk_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge sys_clk);
            if (ack_cnt != a0) break;
        end
        ok = (ack_cnt != a0);
        cpu_req = 1'b0;
        repeat (3) @(negedge sys_clk);
        total++;
        if (wen_cnt != w0 + 1 || wen_at - n != 5 || wen_din !== 32'h1111_BB22)
            $display("FAIL clken_wen: got cnt=%0d lat=%0d din=%h expected 1 5 1111bb22",
                     wen_cnt - w0, wen_at - n, wen_din);
        else passed++;
        total++;
        if (!ok || ack_cnt != a0 + 1 || ack_at - n != 6)
            $display("FAIL clken_ack: got cnt=%0d lat=%0d expected 1 6",
                     ack_cnt - a0, ack_at - n);
        else passed++;
    endtask

    task automatic test_rst_abort();
        int n;
        int a0;
        int w0;
        bit ok;
        a0 = ack_cnt;
        w0 = wen_cnt;
        @(negedge sys_clk);
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = 32'h0000_F008;
        cpu_be    = 4'b1111;
        cpu_wdata = 32'h7777_7777;
        @(negedge sys_clk);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        sys_rst = 1'b0;
        cpu_req = 1'b0;
        repeat (4) @(negedge sys_clk);
        total++;
        if (ack_cnt != a0 || wen_cnt != w0)
            $display("FAIL rst_abort: got ack=%0d wen=%0d expected 0 0",
                     ack_cnt - a0, wen_cnt - w0);
        else passed++;
        access(1'b0, 32'h0000_F004, 4'h0, 32'h0, n, ok);
        cpu_req = 1'b0;
        total++;
        if (!ok || ack_at - n != 2 || ack_rdata !== 32'h1234_5678)
            $display("FAIL rst_recover: got lat=%0d data=%h expected 2 12345678",
                     ack_at - n, ack_rdata);
        else passed++;
    endtask

    task automatic test_back_to_back();
        int n1;
        int n2;
        int first;
        bit ok1;
        bit ok2;
        @(negedge sys_clk);
        access(1'b0, 32'h0000_F004, 4'h0, 32'h0, n1, ok1);
        first = ack_at;
        access(1'b0, 32'h0000_F03C, 4'h0, 32'h0, n2, ok2);
        cpu_req = 1'b0;
        total++;
        if (!ok1 || !ok2 || ack_at - first != 3 || ack_rdata !== 32'hCAFE_F00D)
            $display("FAIL back_to_back: got gap=%0d data=%h expected 3 cafef00d",
                     ack_at - first, ack_rdata);
        else passed++;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            regs[i] = 32'h0100_0000 * i;
            ro[i]   = 32'h0;
        end
        regs[1]  = 32'h1234_5678;
        regs[2]  = 32'h1111_2222;
        ro[2]    = 32'h0000_00FF;
        regs[3]  = 32'h3333_3333;
        ro[3]    = 32'hFFFF_FFFF;
        regs[15] = 32'hCAFE_F00D;

        test_reset();
        test_load_hit();
        test_store_merge();
        test_store_suppressed();
        test_miss();
        test_clk_en();
        test_rst_abort();
        test_back_to_back();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
